// File: rtl/tdc_pkg.sv
// Shared types for the TDC coarse-path measurement sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tdc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        QUIET  = 3'd1,
        ARMED  = 3'd2,
        COUNT  = 3'd3,
        RESULT = 3'd4
    } state_t;

    typedef logic [1:0] status_t;

    localparam status_t ST_OK      = 2'b00;
    localparam status_t ST_TIMEOUT = 2'b01;
    localparam status_t ST_SIMUL   = 2'b10;

endpackage

// File: rtl/tdc_edge_detect.sv
// Rising-edge detector for a clk-synchronous hit line.
// Latency: rise_o is combinational in the cycle the input first reads high.
// Backpressure: none; the level register updates every cycle.
module tdc_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    // Previous-cycle level of the hit line.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/tdc_measure_ctrl.sv
// TDC measurement sequencer: arm, edge-detect start/stop, coarse count, timeout, tagged result.
// Latency: result_valid rises the cycle after the stop edge (or the timeout cycle).
// Backpressure: result held stable in RESULT until result_ready; hits are ignored meanwhile.
// Optional: define TDC_SEQ_TAG_EN to add result_tag (8-bit shot counter, +1 per transfer).
module tdc_measure_ctrl
    import tdc_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int FINE_W      = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              cont,
    input  logic              abort,
    input  logic              start,
    input  logic              stop,
    input  logic [FINE_W-1:0] fine_start,
    input  logic [FINE_W-1:0] fine_stop,
    output logic              busy,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [CNT_W-1:0]  result_coarse,
    output logic [FINE_W-1:0] result_fine_start,
    output logic [FINE_W-1:0] result_fine_stop,
    output logic [1:0]        result_status
`ifdef TDC_SEQ_TAG_EN
    ,
    output logic [7:0]        result_tag
`endif
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYC);

    logic start_e;
    logic stop_e;

    tdc_edge_detect u_start_edge (
        .clk    (clk),
        .reset  (reset),
        .d_i    (start),
        .rise_o (start_e)
    );

    tdc_edge_detect u_stop_edge (
        .clk    (clk),
        .reset  (reset),
        .d_i    (stop),
        .rise_o (stop_e)
    );

    state_t            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [CNT_W-1:0]  coarse_q, coarse_d;
    logic [FINE_W-1:0] fs_q,     fs_d;
    logic [FINE_W-1:0] fp_q,     fp_d;
    status_t           status_q, status_d;
    logic              xfer;

    assign xfer = (state_q == RESULT) && result_ready;

    // State, counter and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            coarse_q <= '0;
            fs_q     <= '0;
            fp_q     <= '0;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            coarse_q <= coarse_d;
            fs_q     <= fs_d;
            fp_q     <= fp_d;
            status_q <= status_d;
        end
    end

    // Next-state and result capture; abort overrides every other transition.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        coarse_d = coarse_q;
        fs_d     = fs_q;
        fp_d     = fp_q;
        status_d = status_q;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = QUIET;
                end
            end
            // Wait for both hit lines low so a stale high level is never taken as an edge.
            QUIET: begin
                if (!start && !stop) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (start_e && stop_e) begin
                    state_d  = RESULT;
                    coarse_d = '0;
                    fs_d     = fine_start;
                    fp_d     = fine_stop;
                    status_d = ST_SIMUL;
                end else if (start_e) begin
                    state_d = COUNT;
                    cnt_d   = '0;
                    fs_d    = fine_start;
                end
            end
            // A stop edge on the timeout cycle still reports OK.
            COUNT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (stop_e) begin
                    state_d  = RESULT;
                    coarse_d = cnt_q + CNT_W'(1);
                    fp_d     = fine_stop;
                    status_d = ST_OK;
                end else if (cnt_q == TO_LAST) begin
                    state_d  = RESULT;
                    coarse_d = TO_VAL;
                    fp_d     = '0;
                    status_d = ST_TIMEOUT;
                end
            end
            RESULT: begin
                if (result_ready) begin
                    state_d = cont ? QUIET : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    assign busy              = (state_q != IDLE);
    assign result_valid      = (state_q == RESULT);
    assign result_coarse     = coarse_q;
    assign result_fine_start = fs_q;
    assign result_fine_stop  = fp_q;
    assign result_status     = status_q;

`ifdef TDC_SEQ_TAG_EN
    logic [7:0] tag_q;

    // Shot counter: advances on every accepted result, including one accepted alongside abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q <= 8'd0;
        end else if (xfer) begin
            tag_q <= tag_q + 8'd1;
        end
    end

    assign result_tag = tag_q;
`else
    logic unused_xfer;
    assign unused_xfer = xfer;
`endif

endmodule
